// File: rtl/mem_access_seq.sv
// mem_access_seq: turns single load/store requests into the AR/M strobe
// sequence of the data MEMORY port, including an optional pointer chase
// (AR <= M) for indirect addressing. All MEMORY-facing outputs are
// registered from the next-state decode, so they change only on clk edges.
module mem_access_seq #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       op_store,
  input  logic       op_indirect,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] ADDR,
  output logic [7:0] R,
  output logic       srcA,
  output logic       wAR,
  output logic       wM,
  input  logic [7:0] M,
  output logic [7:0] rdata,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, SET_AR, WAIT_A, SET_IND, WAIT_B, ACCESS
  } state_t;

  // With a combinational read the wait states are never entered.
  localparam bit         HAS_LAT  = (RD_LAT > 0);
  localparam logic [1:0] CNT_INIT = HAS_LAT ? 2'(RD_LAT - 1) : 2'd0;

  state_t     state;
  state_t     nxt;
  logic       store_q;
  logic       ind_q;
  logic [7:0] wdata_q;
  logic [1:0] cnt;
  logic       accept;

  assign accept = req_valid & req_ready;

  // Request fields are data only; they are meaningful only after an accept.
  // The address itself is captured straight into the ADDR output register.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q <= op_store;
      ind_q   <= op_indirect;
      wdata_q <= wdata;
    end
  end

  // Next-state decode of the access sequence.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SET_AR;
      SET_AR: begin
        // A direct store never reads M, so it needs no settling time.
        if (HAS_LAT && (ind_q || !store_q)) nxt = WAIT_A;
        else if (ind_q)                     nxt = SET_IND;
        else                                nxt = ACCESS;
      end
      WAIT_A:  if (cnt == 2'd0) nxt = ind_q ? SET_IND : ACCESS;
      // After the pointer chase only a load has to wait for M again.
      SET_IND: nxt = (HAS_LAT && !store_q) ? WAIT_B : ACCESS;
      WAIT_B:  if (cnt == 2'd0) nxt = ACCESS;
      ACCESS:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, wait counter and registered MEMORY strobes / results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= CNT_INIT;
      req_ready <= 1'b1;
      ADDR      <= 8'h00;
      R         <= 8'h00;
      srcA      <= 1'b0;
      wAR       <= 1'b0;
      wM        <= 1'b0;
      rdata     <= 8'h00;
      done      <= 1'b0;
    end else begin
      state <= nxt;
      // Wait states are never adjacent, so reloading outside them is enough.
      if (state != WAIT_A && state != WAIT_B) cnt <= CNT_INIT;
      else if (cnt != 2'd0)                   cnt <= cnt - 2'd1;
      req_ready <= (nxt == IDLE);
      wAR       <= (nxt == SET_AR) || (nxt == SET_IND);
      srcA      <= (nxt == SET_IND);
      wM        <= (nxt == ACCESS) && store_q;
      done      <= (state == ACCESS);
      if (nxt == SET_AR)              ADDR  <= addr;
      if (nxt == ACCESS && store_q)   R     <= wdata_q;
      if (state == ACCESS && !store_q) rdata <= M;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (RD_LAT=1 and RD_LAT=0), each
// attached to a simple MEMORY model, checked every cycle against a
// request-level model of latency, write strobes and load results.
module tb_mem_access_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: RD_LAT=1, index 1: RD_LAT=0
  logic       rv    [2];
  logic       rr    [2];
  logic       ost   [2];
  logic       oind  [2];
  logic [7:0] ra    [2];
  logic [7:0] rw    [2];
  logic [7:0] maddr [2];
  logic [7:0] mr    [2];
  logic       msrca [2];
  logic       mwar  [2];
  logic       mwm   [2];
  logic [7:0] mrd   [2];
  logic       mdone [2];

  int nvec = 0;
  int nmis = 0;
  int ecnt = 0;

  // MEMORY model with one cycle of read latency.
  logic [7:0] mem0 [256] = '{default: 8'h00};
  logic [7:0] ar0 = 8'h00;
  logic [7:0] m0  = 8'h00;
  always @(posedge clk) begin
    if (mwar[0]) ar0 <= msrca[0] ? m0 : maddr[0];
    if (mwm[0])  mem0[ar0] <= mr[0];
    m0 <= mem0[ar0];
  end

  // MEMORY model with a combinational read.
  logic [7:0] mem1 [256] = '{default: 8'h00};
  logic [7:0] ar1 = 8'h00;
  logic [7:0] m1;
  assign m1 = mem1[ar1];
  always @(posedge clk) begin
    if (mwar[1]) ar1 <= msrca[1] ? m1 : maddr[1];
    if (mwm[1])  mem1[ar1] <= mr[1];
  end

  mem_access_seq #(.RD_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]),
    .op_store(ost[0]), .op_indirect(oind[0]), .addr(ra[0]), .wdata(rw[0]),
    .ADDR(maddr[0]), .R(mr[0]), .srcA(msrca[0]), .wAR(mwar[0]), .wM(mwm[0]),
    .M(m0), .rdata(mrd[0]), .done(mdone[0])
  );

  mem_access_seq #(.RD_LAT(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]),
    .op_store(ost[1]), .op_indirect(oind[1]), .addr(ra[1]), .wdata(rw[1]),
    .ADDR(maddr[1]), .R(mr[1]), .srcA(msrca[1]), .wAR(mwar[1]), .wM(mwm[1]),
    .M(m1), .rdata(mrd[1]), .done(mdone[1])
  );

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Request-level model: one transaction in flight per instance.
  logic [7:0] mmem [2][256] = '{default: '{default: 8'h00}};
  bit         pend [2] = '{0, 0};
  bit         pst  [2];
  int         due  [2];
  logic [7:0] pval [2];
  logic [7:0] xrd  [2] = '{8'h00, 8'h00};

  // Per-cycle compare, then prediction of an accept on the coming edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit         edone;
      bit         ewm;
      int         lt;
      int         l;
      logic [7:0] tgt;
      if (rst) begin
        pend[i] = 1'b0;
        xrd[i]  = 8'h00;
        chk($sformatf("rst_done%0d", i),  int'(mdone[i]), 0);
        chk($sformatf("rst_ready%0d", i), int'(rr[i]), 1);
        chk($sformatf("rst_wAR%0d", i),   int'(mwar[i]), 0);
        chk($sformatf("rst_wM%0d", i),    int'(mwm[i]), 0);
        chk($sformatf("rst_rdata%0d", i), int'(mrd[i]), 0);
      end else begin
        edone = pend[i] && (due[i] == ecnt);
        ewm   = pend[i] && pst[i] && (due[i] == ecnt + 1);
        if (edone) begin
          pend[i] = 1'b0;
          if (!pst[i]) xrd[i] = pval[i];
        end
        chk($sformatf("done%0d", i),   int'(mdone[i]), int'(edone));
        chk($sformatf("wM%0d", i),     int'(mwm[i]), int'(ewm));
        chk($sformatf("wAR&wM%0d", i), int'(mwar[i] & mwm[i]), 0);
        chk($sformatf("ready%0d", i),  int'(rr[i]), int'(!pend[i]));
        chk($sformatf("rdata%0d", i),  int'(mrd[i]), int'(xrd[i]));
        if (rv[i] && !pend[i]) begin
          l   = (i == 0) ? 1 : 0;
          lt  = 3 + (oind[i] ? 1 : 0) + ((oind[i] || !ost[i]) ? l : 0)
                  + ((oind[i] && !ost[i]) ? l : 0);
          tgt = oind[i] ? mmem[i][ra[i]] : ra[i];
          if (ost[i]) mmem[i][tgt] = rw[i];
          else        pval[i] = mmem[i][tgt];
          pend[i] = 1'b1;
          pst[i]  = ost[i];
          due[i]  = ecnt + lt;
        end
      end
    end
  end

  // Snapshots of the strobes per cycle after accept (index = cycle number).
  logic       sn_war  [8];
  logic       sn_srca [8];
  logic       sn_wm   [8];
  logic [7:0] sn_addr [8];
  logic [7:0] sn_r    [8];

  task automatic wait_ready(input int i);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rr[i]) break;
    end
    if (!rr[i]) chk($sformatf("accept_timeout%0d", i), int'(rr[i]), 1);
  endtask

  task automatic run(input int i, input bit st, input bit ind,
                     input logic [7:0] a, input logic [7:0] d, output int lat);
    @(posedge clk); #1;
    rv[i] = 1'b1; ost[i] = st; oind[i] = ind; ra[i] = a; rw[i] = d;
    wait_ready(i);
    @(posedge clk); #1;
    rv[i] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k < 8) begin
        sn_war[k] = mwar[i]; sn_srca[k] = msrca[i]; sn_wm[k] = mwm[i];
        sn_addr[k] = maddr[i]; sn_r[k] = mr[i];
      end
      if (mdone[i]) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; ost[i] = 1'b0; oind[i] = 1'b0; ra[i] = 8'h00; rw[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("init_ready", int'(rr[0]), 1);
    chk("init_addr",  int'(maddr[0]), 0);
    chk("init_r",     int'(mr[0]), 0);
    rst = 1'b0;

    // Direct store then direct load
    run(0, 1, 0, 8'h01, 8'h02, lat);
    chk("st_lat", lat, 3);
    chk("st_war1", int'(sn_war[1]), 1);
    chk("st_addr1", int'(sn_addr[1]), 8'h01);
    chk("st_srca1", int'(sn_srca[1]), 0);
    chk("st_wm2", int'(sn_wm[2]), 1);
    chk("st_r2", int'(sn_r[2]), 8'h02);
    run(0, 0, 0, 8'h01, 8'h00, lat);
    chk("ld_lat", lat, 4);
    chk("ld_rdata", int'(mrd[0]), 8'h02);

    // Indirect load through mem[1] = 0x02
    run(0, 1, 0, 8'h02, 8'h0A, lat);
    run(0, 0, 1, 8'h01, 8'h00, lat);
    chk("ild_lat", lat, 6);
    chk("ild_war3", int'(sn_war[3]), 1);
    chk("ild_srca3", int'(sn_srca[3]), 1);
    chk("ild_rdata", int'(mrd[0]), 8'h0A);

    // Indirect store; rdata untouched, pointer cell untouched
    run(0, 1, 1, 8'h01, 8'h55, lat);
    chk("ist_lat", lat, 5);
    chk("ist_wm4", int'(sn_wm[4]), 1);
    chk("ist_r4", int'(sn_r[4]), 8'h55);
    chk("ist_rdata_held", int'(mrd[0]), 8'h0A);
    run(0, 0, 0, 8'h02, 8'h00, lat);
    chk("ist_target", int'(mrd[0]), 8'h55);
    run(0, 0, 0, 8'h01, 8'h00, lat);
    chk("ist_pointer", int'(mrd[0]), 8'h02);

    // Boundary pointers 0xFF -> 0x00
    run(0, 1, 0, 8'hFF, 8'h00, lat);
    run(0, 1, 0, 8'h00, 8'h77, lat);
    run(0, 0, 1, 8'hFF, 8'h00, lat);
    chk("ptr_ff_rdata", int'(mrd[0]), 8'h77);

    // Back-to-back: req_valid held through three requests
    @(posedge clk); #1;
    rv[0] = 1'b1; ost[0] = 1'b1; oind[0] = 1'b0; ra[0] = 8'h10; rw[0] = 8'h33;
    wait_ready(0);
    @(posedge clk); #1;
    ost[0] = 1'b0; ra[0] = 8'h10;
    wait_ready(0);
    chk("b2b_done1", int'(mdone[0]), 1);
    @(posedge clk); #1;
    ra[0] = 8'h01;
    wait_ready(0);
    chk("b2b_done2", int'(mdone[0]), 1);
    chk("b2b_rdata2", int'(mrd[0]), 8'h33);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    wait_ready(0);
    chk("b2b_rdata3", int'(mrd[0]), 8'h02);

    // Reset during WAIT_B of an indirect load
    @(posedge clk); #1;
    rv[0] = 1'b1; ost[0] = 1'b0; oind[0] = 1'b1; ra[0] = 8'h01;
    wait_ready(0);
    @(posedge clk); #1;
    rv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_setind_war", int'(mwar[0]), 1);
    chk("rst_setind_srca", int'(msrca[0]), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_war", int'(mwar[0]), 0);
    chk("abort_wm", int'(mwm[0]), 0);
    chk("abort_done", int'(mdone[0]), 0);
    chk("abort_ready", int'(rr[0]), 1);
    chk("abort_rdata", int'(mrd[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    run(0, 0, 0, 8'h02, 8'h00, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_rdata", int'(mrd[0]), 8'h55);

    // RD_LAT=0 instance
    run(1, 1, 0, 8'h05, 8'h99, lat);
    chk("l0_st_lat", lat, 3);
    run(1, 0, 0, 8'h05, 8'h00, lat);
    chk("l0_ld_lat", lat, 3);
    chk("l0_ld_rdata", int'(mrd[1]), 8'h99);
    run(1, 1, 0, 8'h06, 8'h05, lat);
    run(1, 0, 1, 8'h06, 8'h00, lat);
    chk("l0_ild_lat", lat, 4);
    chk("l0_ild_rdata", int'(mrd[1]), 8'h99);
    run(1, 1, 1, 8'h06, 8'h44, lat);
    chk("l0_ist_lat", lat, 4);
    run(1, 0, 0, 8'h05, 8'h00, lat);
    chk("l0_ist_rdata", int'(mrd[1]), 8'h44);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
